// File: rtl/counter_seq_pkg.sv
// Shared types for the counter command sequencer.
// Holds the mode/state enums, the default command record and the WHO codes.
package counter_seq_pkg;

  localparam int unsigned CMD_VALUE_W = 4;
  localparam int unsigned CMD_DUR_W   = 8;

  localparam logic [1:0] WHO_LOSER  = 2'b01;
  localparam logic [1:0] WHO_WINNER = 2'b10;

  typedef enum logic [1:0] {
    UP1 = 2'b00,
    UP2 = 2'b01,
    DN1 = 2'b10,
    DN2 = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    HALT
  } seq_state_e;

  typedef struct packed {
    logic                   load;
    mode_e                  mode;
    logic [CMD_VALUE_W-1:0] value;
    logic [CMD_DUR_W-1:0]   dur;
  } cmd_t;

endpackage

// File: rtl/counter_cmd_fifo.sv
// Synchronous command FIFO with flush and full/empty flags.
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module counter_cmd_fifo
  import counter_seq_pkg::*;
#(
  parameter int unsigned DEPTH   = 8,
  parameter type         entry_t = cmd_t
) (
  input  logic   clk,
  input  logic   rst_l,
  input  logic   push,
  input  entry_t push_data,
  input  logic   pop,
  input  logic   flush,
  output entry_t head,
  output logic   full,
  output logic   empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  // Flags and qualified handshakes
  always_comb begin
    full    = (count == (AW+1)'(DEPTH));
    empty   = (count == '0);
    do_push = push && !full;
    do_pop  = pop && !empty;
    head    = mem[rd_ptr];
  end

  // Storage array; no reset needed since reads are gated by the count
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy tracking; flush empties the queue in one edge
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/counter_cmd_sequencer.sv
// Command sequencer in front of the multi-mode game counter.
// Queues load/mode commands and replays them onto ctrl/INIT/loadValue,
// flushing on GAMEOVER and holding the result until result_ack.
// Optional feature macro: CMD_SEQ_STATS_EN (win/lose event counters).
module counter_cmd_sequencer
  import counter_seq_pkg::*;
#(
  parameter int unsigned COUNTER_SIZE = 4,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned DUR_W        = 8
) (
  input  logic                    clk,
  input  logic                    rst_l,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_load,
  input  logic [1:0]              cmd_mode,
  input  logic [COUNTER_SIZE-1:0] cmd_value,
  input  logic [DUR_W-1:0]        cmd_dur,
  output logic [1:0]              ctrl,
  output logic                    INIT,
  output logic [COUNTER_SIZE-1:0] loadValue,
  input  logic                    GAMEOVER,
  input  logic [1:0]              WHO,
  output logic                    busy,
  output logic                    result_vld,
  output logic [1:0]              result_who,
  input  logic                    result_ack
`ifdef CMD_SEQ_STATS_EN
  ,
  output logic [15:0]             win_evt_cnt,
  output logic [15:0]             lose_evt_cnt
`endif
);

  typedef struct packed {
    logic                    load;
    mode_e                   mode;
    logic [COUNTER_SIZE-1:0] value;
    logic [DUR_W-1:0]        dur;
  } entry_t;

  seq_state_e              state;
  mode_e                   cur_mode;
  logic [COUNTER_SIZE-1:0] cur_value;
  logic [DUR_W-1:0]        dur_cnt;

  entry_t                  push_data;
  entry_t                  head;
  logic                    full;
  logic                    empty;
  logic                    push;
  logic                    pop;
  logic                    game_end;
  logic                    run_last;
  seq_state_e              take_state;
  logic [DUR_W-1:0]        take_cnt;

  counter_cmd_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk       (clk),
    .rst_l     (rst_l),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (game_end),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

  // Handshake, pop decision and decode of the FIFO head
  always_comb begin
    game_end        = GAMEOVER && (state != HALT);
    run_last        = (state == RUN) && (dur_cnt <= DUR_W'(1));
    cmd_ready       = rst_l && !full && (state != HALT) && !GAMEOVER;
    push            = cmd_valid && cmd_ready;
    pop             = !empty && !game_end &&
                      ((state == IDLE) || (state == LOAD) || run_last);
    busy            = (state != IDLE) || !empty;
    push_data.load  = cmd_load;
    push_data.mode  = mode_e'(cmd_mode);
    push_data.value = cmd_value;
    push_data.dur   = cmd_dur;
    take_state      = head.load ? LOAD : RUN;
    take_cnt        = '0;
    if (!head.load) take_cnt = (head.dur == '0) ? DUR_W'(1) : head.dur;
  end

  // Sequencer FSM; outputs are a registered image of the command
  // occupying the FSM, so a command popped at edge N drives from N+1
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state      <= IDLE;
      cur_mode   <= UP1;
      cur_value  <= '0;
      dur_cnt    <= '0;
      ctrl       <= '0;
      INIT       <= 1'b0;
      loadValue  <= '0;
      result_vld <= 1'b0;
      result_who <= '0;
    end else if (game_end) begin
      state      <= HALT;
      dur_cnt    <= '0;
      INIT       <= 1'b0;
      result_vld <= 1'b1;
      result_who <= WHO;
    end else begin
      INIT <= (state == LOAD);
      if (state == LOAD) loadValue <= cur_value;
      if (state == RUN)  ctrl      <= cur_mode;
      case (state)
        IDLE, LOAD: begin
          if (pop) begin
            state     <= take_state;
            cur_mode  <= head.mode;
            cur_value <= head.value;
            dur_cnt   <= take_cnt;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          if (run_last) begin
            if (pop) begin
              state     <= take_state;
              cur_mode  <= head.mode;
              cur_value <= head.value;
              dur_cnt   <= take_cnt;
            end else begin
              state   <= IDLE;
              dur_cnt <= '0;
            end
          end else begin
            dur_cnt <= dur_cnt - 1'b1;
          end
        end
        HALT: begin
          if (result_ack) begin
            state      <= IDLE;
            result_vld <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CMD_SEQ_STATS_EN
  // Saturating per-outcome game counters, sampled on the game-end edge
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      win_evt_cnt  <= '0;
      lose_evt_cnt <= '0;
    end else if (game_end) begin
      if (WHO == WHO_WINNER && win_evt_cnt != '1)  win_evt_cnt  <= win_evt_cnt + 1'b1;
      if (WHO == WHO_LOSER  && lose_evt_cnt != '1) lose_evt_cnt <= lose_evt_cnt + 1'b1;
    end
  end
`endif

endmodule
